audio_frame_packer: RTL and testbench

- Sits directly downstream of the 24-bit I2S capture stage, on the same left/right sample bus and ready strobe that feed the VU meter.
- Buffers stereo frames in a small FIFO. Serialises each frame into a fixed byte packet for the UART/comm path.
- Byte output uses a valid/ready handshake, so a slow UART transmitter never corrupts a frame. Overflow is flagged instead of silently lost.

---
 rtl/audio_frame_packer.sv | 118 +++++++++++
 tb/tb_audio_frame_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_packer.sv
// audio_frame_packer: FIFO-buffered stereo frames serialised into SYNC+6-byte packets over valid/ready.
// Define AUDIO_FRAME_PACKER_CHECKSUM_EN to append an XOR checksum byte (8-byte packets).
module audio_frame_packer #(
    parameter int         SAMPLE_W  = 24,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     sample_stb_i,
    input  logic [SAMPLE_W-1:0]      left_i,
    input  logic [SAMPLE_W-1:0]      right_i,
    output logic [7:0]               byte_o,
    output logic                     byte_valid_o,
    input  logic                     byte_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     clr_overflow_i,
    output logic                     busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = 2 * SAMPLE_W;
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;
    logic [7:0] csum_q;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif
    state_t state_q, state_d;
    logic [FW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [FW-1:0] frame_q;
    logic [2:0]    idx_q;
    logic          overflow_q;
    logic          push, pop, full, accept, xfer;
    assign push   = sample_stb_i & enable_i;
    assign pop    = (state_q == IDLE) && (level_q != '0);
    assign full   = level_q == LW'(DEPTH);
    // A full FIFO still takes a frame when the same cycle frees a slot.
    assign accept = push & (~full | pop);
    assign xfer   = byte_valid_o & byte_ready_i;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign busy_o     = state_q != IDLE;
    always_ff @(posedge clk_i) begin
        if (accept)
            mem_q[wr_ptr_q] <= {left_i, right_i};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            frame_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            level_q    <= level_q + LW'(accept) - LW'(pop);
            overflow_q <= (push & ~accept) | (overflow_q & ~clr_overflow_i);
            if (accept)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                frame_q  <= mem_q[rd_ptr_q];
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end
            if (state_q == HDR && xfer)
                idx_q <= '0;
            if (state_q == DATA && xfer) begin
                idx_q   <= idx_q + 1'b1;
                frame_q <= {frame_q[FW-9:0], 8'h00};
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
                csum_q  <= csum_q ^ frame_q[FW-1 -: 8];
`endif
            end
        end
    end
    always_comb begin
        state_d      = state_q;
        byte_o       = '0;
        byte_valid_o = 1'b0;
        case (state_q)
            IDLE: state_d = pop ? HDR : IDLE;
            HDR: begin
                byte_o       = SYNC_BYTE;
                byte_valid_o = 1'b1;
                state_d      = byte_ready_i ? DATA : HDR;
            end
            DATA: begin
                byte_o       = frame_q[FW-1 -: 8];
                byte_valid_o = 1'b1;
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
                state_d      = (byte_ready_i && idx_q == 3'd5) ? CSUM : DATA;
`else
                state_d      = (byte_ready_i && idx_q == 3'd5) ? IDLE : DATA;
`endif
            end
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
            CSUM: begin
                byte_o       = csum_q;
                byte_valid_o = 1'b1;
                state_d      = byte_ready_i ? IDLE : CSUM;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_audio_frame_packer.sv
// tb_audio_frame_packer: table vectors plus corner sequences, bytes checked against a scoreboard queue.
module tb_audio_frame_packer;
    localparam int DEPTH = 16;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1, enable_i = 1'b1, sample_stb_i = 1'b0;
    logic [23:0] left_i = '0, right_i = '0;
    logic [7:0]  byte_o;
    logic        byte_valid_o, byte_ready_i = 1'b1;
    logic [4:0]  level_o;
    logic        overflow_o, clr_overflow_i = 1'b0, busy_o;
    logic [7:0]  exp_q [$];
    int          checks = 0, errors = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;

    always #5 clk = ~clk;

    audio_frame_packer #(.SAMPLE_W(24), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .sample_stb_i(sample_stb_i),
        .left_i(left_i), .right_i(right_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i), .level_o(level_o), .overflow_o(overflow_o),
        .clr_overflow_i(clr_overflow_i), .busy_o(busy_o)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [55:0] bytes;
        logic [7:0]  cs;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference packet built from the sample values.
    task automatic push_exp(input logic [23:0] l, input logic [23:0] r);
        logic [47:0] f;
        logic [7:0]  cs;
        f  = {l, r};
        cs = '0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(f[47 - 8 * i -: 8]);
            cs ^= f[47 - 8 * i -: 8];
        end
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        sample_stb_i = 1'b1;
        left_i       = l;
        right_i      = r;
        tick();
        sample_stb_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o || level_o != 0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_left", 48'(exp_q.size()), 48'd0);
        check("drain_busy", 48'(busy_o), 48'd0);
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 48'(byte_valid_o), 48'd1);
                check("hold_byte", 48'(byte_o), 48'(prev_byte));
            end
            if (byte_valid_o && byte_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte got %0h expected none at %0t", byte_o, $time);
                end else begin
                    check("pkt_byte", 48'(byte_o), 48'(exp_q.pop_front()));
                end
            end
            prev_stall = byte_valid_o && !byte_ready_i;
            prev_byte  = byte_o;
        end
    end

    initial begin
        int n;
        tbl[0] = '{24'h123456, 24'hABCDEF, 56'hA5123456ABCDEF, 8'hF9};
        tbl[1] = '{24'h000000, 24'h000000, 56'hA5000000000000, 8'h00};
        tbl[2] = '{24'hFFFFFF, 24'h800000, 56'hA5FFFFFF800000, 8'h7F};
        tbl[3] = '{24'h7FFFFF, 24'hA5A5A5, 56'hA57FFFFFA5A5A5, 8'hDA};

        tick();
        check("rst_byte", 48'(byte_o), 48'd0);
        check("rst_valid", 48'(byte_valid_o), 48'd0);
        check("rst_level", 48'(level_o), 48'd0);
        check("rst_ovf", 48'(overflow_o), 48'd0);
        check("rst_busy", 48'(busy_o), 48'd0);
        rst_i = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            for (int b = 0; b < 7; b++)
                exp_q.push_back(tbl[v].bytes[55 - 8 * b -: 8]);
`ifdef AUDIO_FRAME_PACKER_CHECKSUM_EN
            exp_q.push_back(tbl[v].cs);
`endif
            strobe(tbl[v].l, tbl[v].r);
            if (v == 0) begin
                check("lat_level", 48'(level_o), 48'd1);
                check("lat_valid_n1", 48'(byte_valid_o), 48'd0);
                tick();
                check("lat_valid_n2", 48'(byte_valid_o), 48'd1);
                check("lat_sync", 48'(byte_o), 48'hA5);
            end
            drain();
        end

        enable_i = 1'b0;
        strobe(24'h111111, 24'h222222);
        check("en_low_level", 48'(level_o), 48'd0);
        check("en_low_busy", 48'(busy_o), 48'd0);
        enable_i = 1'b1;

        push_exp(24'hC0FFEE, 24'h0BADF0);
        strobe(24'hC0FFEE, 24'h0BADF0);
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 200) begin
            byte_ready_i = ~byte_ready_i;
            tick();
            n++;
        end
        byte_ready_i = 1'b1;
        drain();

        // One frame sits in the hold register, so 17 strobes fill the FIFO and the 18th drops.
        byte_ready_i = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            push_exp(24'(i), 24'(i + 100));
            strobe(24'(i), 24'(i + 100));
        end
        check("full_level", 48'(level_o), 48'd16);
        check("full_no_ovf", 48'(overflow_o), 48'd0);
        strobe(24'd18, 24'd118);
        check("ovf_level", 48'(level_o), 48'd16);
        check("ovf_set", 48'(overflow_o), 48'd1);
        clr_overflow_i = 1'b1;
        strobe(24'd19, 24'd119);
        clr_overflow_i = 1'b0;
        check("ovf_set_wins", 48'(overflow_o), 48'd1);
        check("ovf_level2", 48'(level_o), 48'd16);
        byte_ready_i = 1'b1;
        drain();
        check("ovf_sticky", 48'(overflow_o), 48'd1);
        clr_overflow_i = 1'b1;
        tick();
        clr_overflow_i = 1'b0;
        check("ovf_clr", 48'(overflow_o), 48'd0);

        for (int i = 0; i < 40; i++) begin
            push_exp(24'(i * 3 + 1), ~24'(i * 3 + 1));
            strobe(24'(i * 3 + 1), ~24'(i * 3 + 1));
            repeat (7) tick();
        end
        drain();
        check("wrap_no_ovf", 48'(overflow_o), 48'd0);

        byte_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_exp(24'(i + 500), 24'(i + 900));
            strobe(24'(i + 500), 24'(i + 900));
        end
        check("pp_full", 48'(level_o), 48'd16);
        byte_ready_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_o && n < 50);
        check("pp_idle_seen", 48'(busy_o), 48'd0);
        push_exp(24'hFACADE, 24'hBEEF01);
        strobe(24'hFACADE, 24'hBEEF01);
        check("pp_level", 48'(level_o), 48'd16);
        check("pp_no_ovf", 48'(overflow_o), 48'd0);
        check("pp_busy", 48'(busy_o), 48'd1);
        drain();

        byte_ready_i = 1'b0;
        push_exp(24'h123456, 24'h789ABC);
        strobe(24'h123456, 24'h789ABC);
        n = 0;
        while (!byte_valid_o && n < 20) begin
            tick();
            n++;
        end
        byte_ready_i = 1'b1;
        repeat (4) tick();
        byte_ready_i = 1'b0;
        check("rst_mid_idx3", 48'(byte_o), 48'h78);
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        check("rst_mid_valid", 48'(byte_valid_o), 48'd0);
        check("rst_mid_level", 48'(level_o), 48'd0);
        check("rst_mid_busy", 48'(busy_o), 48'd0);
        rst_i = 1'b0;
        byte_ready_i = 1'b1;
        push_exp(24'h0A0B0C, 24'h0D0E0F);
        strobe(24'h0A0B0C, 24'h0D0E0F);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
